// File: rtl/multicycle_ctrl_pkg.sv
// Shared types for the RV32I multicycle controller: FSM states, opcodes and
// datapath mux-select encodings.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, JAL, BRANCH, TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle. master = controller side,
// slave = datapath side.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       mem_req;
  logic       pc_write;
  logic       ir_write;
  logic       adr_src;
  logic       mem_write;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] result_src;
  logic       instret;
  logic       illegal;

  modport master (
    input  opcode, funct3, zero, mem_ready,
    output mem_req, pc_write, ir_write, adr_src, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, instret, illegal
  );

  modport slave (
    output opcode, funct3, zero, mem_ready,
    input  mem_req, pc_write, ir_write, adr_src, mem_write, reg_write,
           alu_src_a, alu_src_b, alu_op, result_src, instret, illegal
  );
endinterface

// File: rtl/mc_op_decode.sv
// Combinational opcode/funct3 classifier. Only beq/bne are supported branches;
// every unrecognised encoding is reported as illegal.
module mc_op_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  output logic       is_load,
  output logic       is_store,
  output logic       is_rtype,
  output logic       is_itype,
  output logic       is_jal,
  output logic       is_branch,
  output logic       is_illegal
);
  assign is_load    = (opcode == OP_LOAD);
  assign is_store   = (opcode == OP_STORE);
  assign is_rtype   = (opcode == OP_RTYPE);
  assign is_itype   = (opcode == OP_ITYPE);
  assign is_jal     = (opcode == OP_JAL);
  assign is_branch  = (opcode == OP_BRANCH) && (funct3[2:1] == 2'b00);
  assign is_illegal = !(is_load || is_store || is_rtype || is_itype ||
                        is_jal || is_branch);
endmodule

// File: rtl/multicycle_ctrl.sv
// Main sequencing FSM of the RV32I multicycle datapath.
// Define MC_MEM_WAIT_EN to make memory states wait for mem_ready.
//
// state    | meaning
// FETCH    | read instr at PC, IR <= mem, PC <= PC+4
// DECODE   | classify opcode, precompute branch/jump target
// MEMADR   | rs1 + imm effective address
// MEMREAD  | load data access
// MEMWB    | rd <= load data (retire)
// MEMWRITE | store data access (retire)
// EXECR    | rs1 op rs2
// EXECI    | rs1 op imm
// ALUWB    | rd <= ALU out register (retire)
// JAL      | PC <= target, compute link address old PC + 4
// BRANCH   | compare rs1/rs2, conditional PC load (retire)
// TRAP     | unsupported opcode, parked until reset
module multicycle_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  multicycle_ctrl_if.master bus
);
  state_t state, state_next;
  logic   illegal_q;
  logic   mem_done;
  logic   is_load, is_store, is_rtype, is_itype, is_jal, is_branch, is_illegal;
  logic   mem_req, pc_write, ir_write, mem_write, reg_write, instret;

  mc_op_decode u_decode (
    .opcode    (bus.opcode),
    .funct3    (bus.funct3),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_rtype  (is_rtype),
    .is_itype  (is_itype),
    .is_jal    (is_jal),
    .is_branch (is_branch),
    .is_illegal(is_illegal)
  );

`ifdef MC_MEM_WAIT_EN
  assign mem_done = bus.mem_ready;
`else
  assign mem_done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE && is_illegal)
        illegal_q <= 1'b1;
    end
  end

  always_comb begin
    state_next     = state;
    mem_req        = 1'b0;
    pc_write       = 1'b0;
    ir_write       = 1'b0;
    mem_write      = 1'b0;
    reg_write      = 1'b0;
    instret        = 1'b0;
    bus.adr_src    = 1'b0;
    bus.alu_src_a  = SRC_A_PC;
    bus.alu_src_b  = SRC_B_RS2;
    bus.alu_op     = ALU_ADD;
    bus.result_src = RES_ALUOUT;
    unique case (state)
      FETCH: begin
        mem_req        = 1'b1;
        ir_write       = mem_done;
        pc_write       = mem_done;
        bus.alu_src_b  = SRC_B_FOUR;
        bus.result_src = RES_ALU;
        state_next     = mem_done ? DECODE : FETCH;
      end
      DECODE: begin
        bus.alu_src_a = SRC_A_OLDPC;
        bus.alu_src_b = SRC_B_IMM;
        if (is_load || is_store) state_next = MEMADR;
        else if (is_rtype)       state_next = EXECR;
        else if (is_itype)       state_next = EXECI;
        else if (is_jal)         state_next = JAL;
        else if (is_branch)      state_next = BRANCH;
        else                     state_next = TRAP;
      end
      MEMADR: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_IMM;
        state_next    = is_load ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        mem_req     = 1'b1;
        bus.adr_src = 1'b1;
        state_next  = mem_done ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        reg_write      = 1'b1;
        instret        = 1'b1;
        bus.result_src = RES_MEM;
        state_next     = FETCH;
      end
      MEMWRITE: begin
        mem_req     = 1'b1;
        mem_write   = 1'b1;
        instret     = mem_done;
        bus.adr_src = 1'b1;
        state_next  = mem_done ? FETCH : MEMWRITE;
      end
      EXECR: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_op    = ALU_FUNCT;
        state_next    = ALUWB;
      end
      EXECI: begin
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_src_b = SRC_B_IMM;
        bus.alu_op    = ALU_FUNCT;
        state_next    = ALUWB;
      end
      ALUWB: begin
        reg_write  = 1'b1;
        instret    = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        pc_write      = 1'b1;
        bus.alu_src_a = SRC_A_OLDPC;
        bus.alu_src_b = SRC_B_FOUR;
        state_next    = ALUWB;
      end
      BRANCH: begin
        // funct3[0] selects bne, which inverts the zero test
        pc_write      = bus.zero ^ bus.funct3[0];
        instret       = 1'b1;
        bus.alu_src_a = SRC_A_RS1;
        bus.alu_op    = ALU_SUB;
        state_next    = FETCH;
      end
      TRAP:    state_next = TRAP;
      default: state_next = FETCH;
    endcase
  end

  assign bus.mem_req   = rst_n & mem_req;
  assign bus.pc_write  = rst_n & pc_write;
  assign bus.ir_write  = rst_n & ir_write;
  assign bus.mem_write = rst_n & mem_write;
  assign bus.reg_write = rst_n & reg_write;
  assign bus.instret   = rst_n & instret;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: each instruction is expanded into its
// list of per-cycle output vectors and compared against the DUT every cycle.
module tb_multicycle_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  multicycle_ctrl_if bus();
  multicycle_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  // v bits: [14]mem_req [13]pc_write [12]ir_write [11]adr_src [10]mem_write
  // [9]reg_write [8:7]a [6:5]b [4:3]alu_op [2:1]result_src [0]instret
  typedef struct packed {
    logic [14:0] v;
    logic        mem;
    logic        br;
  } step_t;

  localparam logic [14:0] STROBE_MASK = 15'b111011000000001;

  int checks = 0;
  int errors = 0;
  step_t plan[$];
  logic [9:0] dir_q[$];
  int idx, cls, lat, waits, trap_cnt, rst_cnt, dut_ret, mdl_ret;
  logic trapped, need_new, first_cycle, stall;
  logic [14:0] act, e;
  logic [6:0] op;
  logic [2:0] f3;
  step_t s;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, a, x);
    end
  endtask

  function automatic step_t mk(input logic mreq, pcw, irw, adr, mw, rw,
                               input logic [1:0] a, b, aop, res,
                               input logic ir, mem, br);
    return step_t'({mreq, pcw, irw, adr, mw, rw, a, b, aop, res, ir, mem, br});
  endfunction

  // 0 load, 1 store, 2 R, 3 I, 4 jal, 5 branch, 6 illegal
  function automatic int classify(input logic [6:0] o, input logic [2:0] f);
    case (o)
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b0110011: return 2;
      7'b0010011: return 3;
      7'b1101111: return 4;
      7'b1100011: return (f == 3'b000 || f == 3'b001) ? 5 : 6;
      default:    return 6;
    endcase
  endfunction

  function automatic int base_lat(input int c);
    case (c)
      0:       return 5;
      5:       return 3;
      default: return 4;
    endcase
  endfunction

  task automatic build_plan(input int c);
    plan.delete();
    plan.push_back(mk(1,1,1,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0, 1, 0));
    plan.push_back(mk(0,0,0,0,0,0, 2'b01,2'b01,2'b00,2'b00, 0, 0, 0));
    case (c)
      0: begin
        plan.push_back(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0, 0, 0));
        plan.push_back(mk(1,0,0,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0, 1, 0));
        plan.push_back(mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b01, 1, 0, 0));
      end
      1: begin
        plan.push_back(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b00,2'b00, 0, 0, 0));
        plan.push_back(mk(1,0,0,1,1,0, 2'b00,2'b00,2'b00,2'b00, 1, 1, 0));
      end
      2: begin
        plan.push_back(mk(0,0,0,0,0,0, 2'b10,2'b00,2'b10,2'b00, 0, 0, 0));
        plan.push_back(mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1, 0, 0));
      end
      3: begin
        plan.push_back(mk(0,0,0,0,0,0, 2'b10,2'b01,2'b10,2'b00, 0, 0, 0));
        plan.push_back(mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1, 0, 0));
      end
      4: begin
        plan.push_back(mk(0,1,0,0,0,0, 2'b01,2'b10,2'b00,2'b00, 0, 0, 0));
        plan.push_back(mk(0,0,0,0,0,1, 2'b00,2'b00,2'b00,2'b00, 1, 0, 0));
      end
      5: plan.push_back(mk(0,0,0,0,0,0, 2'b10,2'b00,2'b01,2'b00, 1, 0, 1));
      default: ;
    endcase
  endtask

  task automatic pick(output logic [6:0] o, output logic [2:0] f);
    int r;
    if (dir_q.size() > 0) begin
      {o, f} = dir_q.pop_front();
      return;
    end
    r = $urandom_range(0, 15);
    f = 3'($urandom);
    case (r)
      0, 1:   o = 7'b0000011;
      2, 3:   o = 7'b0100011;
      4, 5:   o = 7'b0110011;
      6, 7:   o = 7'b0010011;
      8, 9:   o = 7'b1101111;
      10, 11, 12: begin o = 7'b1100011; f = {2'b00, f[0]}; end
      13:     o = 7'b1100011;
      14:     o = 7'b1111111;
      default: o = 7'($urandom);
    endcase
  endtask

  initial begin
    dir_q = '{{7'b0110011, 3'b000}, {7'b0000011, 3'b010}, {7'b1100011, 3'b000},
              {7'b1100011, 3'b000}, {7'b1100011, 3'b001}, {7'b1100011, 3'b001},
              {7'b1101111, 3'b000}, {7'b0100011, 3'b010}, {7'b0010011, 3'b000},
              {7'b1111111, 3'b000}};
    bus.opcode = 7'b0; bus.funct3 = 3'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    idx = 0; cls = 0; lat = 0; waits = 0; trap_cnt = 0; dut_ret = 0; mdl_ret = 0;
    trapped = 1'b0; need_new = 1'b1; first_cycle = 1'b1; stall = 1'b0;
    rst_cnt = 3;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (rst_cnt > 0) begin rst_n = 1'b0; rst_cnt--; end
      else rst_n = 1'b1;
      if (rst_n && need_new) begin
        pick(op, f3);
        bus.opcode = op;
        bus.funct3 = f3;
        cls = classify(op, f3);
        build_plan(cls);
        need_new = 1'b0;
        idx = 0; lat = 0; waits = 0;
      end
      bus.zero = 1'($urandom);
      bus.mem_ready = ($urandom_range(0, 2) != 0);
      if (first_cycle && rst_n) bus.mem_ready = 1'b1;
      #1;
      act = {bus.mem_req, bus.pc_write, bus.ir_write, bus.adr_src, bus.mem_write,
             bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
             bus.result_src, bus.instret};
      stall = 1'b0;
      if (!rst_n) begin
        chk("reset_strobes", 32'(act & STROBE_MASK), 32'd0);
      end else if (trapped) begin
        chk("trap_outputs", 32'(act), 32'd0);
        chk("trap_illegal", 32'(bus.illegal), 32'd1);
      end else begin
        s = plan[idx];
        e = s.v;
        if (s.br) e[13] = bus.zero ^ bus.funct3[0];
`ifdef MC_MEM_WAIT_EN
        if (s.mem && !bus.mem_ready) begin
          stall = 1'b1;
          e[13] = 1'b0; e[12] = 1'b0; e[0] = 1'b0;
        end
`endif
        chk("outputs", 32'(act), 32'(e));
        chk("illegal_low", 32'(bus.illegal), 32'd0);
        lat++;
        if (stall) waits++;
        if (e[0]) begin
          mdl_ret++;
          chk("latency", 32'(lat), 32'(base_lat(cls) + waits));
        end
        if (first_cycle)
          chk("first_fetch", {28'd0, bus.ir_write, bus.pc_write, bus.alu_src_b}, 32'hE);
      end
      if (bus.instret) dut_ret++;

      if (!rst_n) begin
        trapped = 1'b0; need_new = 1'b1; first_cycle = 1'b1; trap_cnt = 0;
      end else begin
        first_cycle = 1'b0;
        if (trapped) begin
          trap_cnt++;
          if (trap_cnt == 10) begin
            chk("illegal_held_10", 32'(bus.illegal), 32'd1);
            rst_cnt = 2;
          end
        end else if (!stall) begin
          idx++;
          if (cls == 6 && idx == 2) trapped = 1'b1;
          else if (idx == plan.size()) need_new = 1'b1;
        end
        if (!trapped && rst_cnt == 0 && $urandom_range(0, 299) == 0)
          rst_cnt = $urandom_range(1, 3);
      end
    end
    chk("instret_count", 32'(dut_ret), 32'(mdl_ret));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
